// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, drives the instruction-memory
// handshake and fills the IF/ID register through a one-entry skid buffer.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [1:0]  pc_control_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jr_target_i,
    input  logic [31:0] jump_target_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_d_o,
    output logic        valid_d_o
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] WORD_MASK  = ~XLEN'(3);
    localparam logic [XLEN-1:0] RESET_PC_A = RESET_PC & WORD_MASK;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_KILL = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifid_t;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic            imem_req_q, imem_req_d;
    logic [XLEN-1:0] imem_addr_q, imem_addr_d;
    ifid_t           ifid_q, ifid_d;
    logic            valid_d_q, valid_d_d;
    ifid_t           buf_q, buf_d;
    logic            buf_valid_q, buf_valid_d;

    logic            ld;
    logic            redirect;
    logic            run_xfer;
    logic [XLEN-1:0] target;

    // Per-cycle handshake and decode-stage control terms.
    always_comb begin
        ld       = ~valid_d_q | ~stall_i;
        redirect = (state_q == ST_RUN) & valid_d_q & ~stall_i & (pc_control_i != 2'd0);
        run_xfer = (state_q == ST_RUN) & imem_req_q & imem_ready_i;
        case (pc_control_i)
            2'd1:    target = branch_target_i & WORD_MASK;
            2'd2:    target = jr_target_i & WORD_MASK;
            2'd3:    target = jump_target_i & WORD_MASK;
            default: target = pc_f_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: KILL drains a request that a redirect made stale.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (redirect && imem_req_q && !imem_ready_i) begin
                    state_d = ST_KILL;
                end
            end
            ST_KILL: begin
                if (imem_ready_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Request outputs for the coming cycle; KILL holds the abandoned address.
    always_comb begin
        imem_req_d  = 1'b0;
        imem_addr_d = pc_f_d;
        case (state_d)
            ST_RUN: imem_req_d = ~buf_valid_d;
            ST_KILL: begin
                imem_req_d  = 1'b1;
                imem_addr_d = imem_addr_q;
            end
            default: imem_req_d = 1'b0;
        endcase
    end

    // Fetch PC, skid buffer and IF/ID next values.
    always_comb begin
        pc_f_d      = pc_f_q;
        ifid_d      = ifid_q;
        valid_d_d   = valid_d_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;

        if (run_xfer) begin
            pc_f_d = pc_f_q + XLEN'(4);
        end

        if (redirect) begin
            pc_f_d      = target;
            valid_d_d   = 1'b0;
            buf_valid_d = 1'b0;
        end else if (ld) begin
            if (buf_valid_q) begin
                ifid_d      = buf_q;
                valid_d_d   = 1'b1;
                buf_valid_d = 1'b0;
            end else if (run_xfer) begin
                ifid_d.pc    = pc_f_q;
                ifid_d.instr = imem_rdata_i;
                valid_d_d    = 1'b1;
            end else begin
                valid_d_d = 1'b0;
            end
        end else if (run_xfer) begin
            // Buffer is empty whenever a request is outstanding, so no overwrite.
            buf_d.pc    = pc_f_q;
            buf_d.instr = imem_rdata_i;
            buf_valid_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pc_f_q      <= RESET_PC_A;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC_A;
            ifid_q      <= '0;
            valid_d_q   <= 1'b0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            pc_f_q      <= pc_f_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            ifid_q      <= ifid_d;
            valid_d_q   <= valid_d_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    assign imem_req_o  = imem_req_q;
    assign imem_addr_o = imem_addr_q;
    assign instr_d_o   = ifid_q.instr;
    assign pc_d_o      = ifid_q.pc;
    assign valid_d_o   = valid_d_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle request checks plus a scoreboard of
// the PCs expected to reach IF/ID, drained by a monitor on each IF/ID load.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk           = 1'b0;
    logic        reset_n       = 1'b0;
    logic [1:0]  pc_control    = 2'd0;
    logic [31:0] branch_target = '0;
    logic [31:0] jr_target     = '0;
    logic [31:0] jump_target   = '0;
    logic        stall         = 1'b0;
    logic        imem_ready    = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        vd_prev = 1'b0;

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .pc_control_i   (pc_control),
        .branch_target_i(branch_target),
        .jr_target_i    (jr_target),
        .jump_target_i  (jump_target),
        .stall_i        (stall),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_ready_i   (imem_ready),
        .imem_rdata_i   (imem_rdata),
        .instr_d_o      (instr_d),
        .pc_d_o         (pc_d),
        .valid_d_o      (valid_d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] ^ a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, "_req"}, 32'(imem_req), 32'(req));
        if (req) chk({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Release reset at a negedge and check the first request after the BOOT cycle.
    task automatic restart();
        repeat (2) cyc();
        reset_n    = 1'b1;
        imem_ready = 1'b1;
        cyc();
        chk("restart_valid", 32'(valid_d), 32'd0);
        chk_fetch("restart", 1'b1, RST_PC);
        exp_q.push_back(RST_PC);
    endtask

    // Scoreboard drain: every IF/ID load of a live instruction pops one entry.
    always @(posedge clk) begin
        logic        ld;
        logic [31:0] e;
        #2;
        ld = !vd_prev || !stall;
        if (ld && valid_d === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL ifid_unexpected: observed pc_d %h expected no load", pc_d);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ifid_pc", pc_d, e);
                chk("ifid_instr", instr_d, mem_word(e));
            end
        end
        vd_prev = valid_d;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) cyc();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(valid_d), 32'd0);
        chk("rst_pc_d", pc_d, 32'd0);
        chk("rst_instr_d", instr_d, 32'd0);

        // Straight-line fetch at full rate.
        reset_n    = 1'b1;
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 0) chk("boot_bubble", 32'(valid_d), 32'd0);
            chk_fetch("seq", 1'b1, RST_PC + 32'(4 * i));
            exp_q.push_back(RST_PC + 32'(4 * i));
        end

        // Three-cycle stall: one word lands in the skid buffer.
        cyc();
        chk_fetch("stall_pre", 1'b1, 32'h3010);
        chk("stall_pre_pc_d", pc_d, 32'h300C);
        exp_q.push_back(32'h3010);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk_fetch("stall_hold", 1'b0, 32'h0);
            chk("stall_hold_pc_d", pc_d, 32'h300C);
            chk("stall_hold_valid", 32'(valid_d), 32'd1);
        end
        cyc();
        chk_fetch("stall_rel", 1'b0, 32'h0);
        chk("stall_rel_pc_d", pc_d, 32'h300C);
        stall = 1'b0;
        cyc();
        chk("unbuf_pc_d", pc_d, 32'h3010);
        chk_fetch("unbuf", 1'b1, 32'h3014);
        exp_q.push_back(32'h3014);

        // Taken branch while the request at 0x3018 completes (discarded).
        cyc();
        chk_fetch("br_pre", 1'b1, 32'h3018);
        chk("br_pre_pc_d", pc_d, 32'h3014);
        pc_control    = 2'd1;
        branch_target = 32'h0000_3100;
        cyc();
        pc_control = 2'd0;
        chk("br_bubble", 32'(valid_d), 32'd0);
        chk_fetch("br_tgt", 1'b1, 32'h3100);
        exp_q.push_back(32'h3100);
        cyc();
        chk("br_valid", 32'(valid_d), 32'd1);
        chk("br_pc_d", pc_d, 32'h3100);
        chk_fetch("br_next", 1'b1, 32'h3104);
        exp_q.push_back(32'h3104);
        cyc();
        chk_fetch("br_next2", 1'b1, 32'h3108);
        exp_q.push_back(32'h3108);

        // Jump while the request at 0x310C is still waiting: KILL holds it.
        cyc();
        chk_fetch("kill_pre", 1'b1, 32'h310C);
        imem_ready  = 1'b0;
        pc_control  = 2'd3;
        jump_target = 32'h0000_3400;
        for (int i = 0; i < 3; i++) begin
            cyc();
            pc_control = 2'd0;
            chk("kill_valid", 32'(valid_d), 32'd0);
            chk_fetch("kill_hold", 1'b1, 32'h310C);
        end
        imem_ready = 1'b1;
        cyc();
        chk("kill_done_valid", 32'(valid_d), 32'd0);
        chk_fetch("jmp_tgt", 1'b1, 32'h3400);
        exp_q.push_back(32'h3400);

        // jr under stall is held off, then taken with the low bits cleared.
        cyc();
        chk("jr_pre_pc_d", pc_d, 32'h3400);
        chk_fetch("jr_pre", 1'b1, 32'h3404);
        stall      = 1'b1;
        pc_control = 2'd2;
        jr_target  = 32'h0000_3503;
        cyc();
        chk("jr_stalled_valid", 32'(valid_d), 32'd1);
        chk("jr_stalled_pc_d", pc_d, 32'h3400);
        chk_fetch("jr_stalled", 1'b0, 32'h0);
        stall = 1'b0;
        cyc();
        pc_control = 2'd0;
        chk("jr_bubble", 32'(valid_d), 32'd0);
        chk_fetch("jr_tgt", 1'b1, 32'h3500);
        exp_q.push_back(32'h3500);
        cyc();
        chk("jr_pc_d", pc_d, 32'h3500);
        chk_fetch("jr_next", 1'b1, 32'h3504);
        imem_ready = 1'b0;

        // Reset in the middle of an outstanding transfer.
        cyc();
        chk_fetch("mid_xfer", 1'b1, 32'h3504);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_xfer_req", 32'(imem_req), 32'd0);
        chk("arst_xfer_valid", 32'(valid_d), 32'd0);
        restart();

        // Reset with IF/ID held and the skid buffer full.
        cyc();
        chk("fill_pc_d", pc_d, RST_PC);
        chk_fetch("fill", 1'b1, RST_PC + 32'd4);
        stall = 1'b1;
        cyc();
        chk_fetch("full_buf", 1'b0, 32'h0);
        chk("full_buf_valid", 32'(valid_d), 32'd1);
        #2 reset_n = 1'b0;
        stall = 1'b0;
        #1;
        chk("arst_buf_req", 32'(imem_req), 32'd0);
        chk("arst_buf_valid", 32'(valid_d), 32'd0);
        chk("arst_buf_pc_d", pc_d, 32'd0);
        restart();

        // Jump to the top word, stall with an empty IF/ID, then wrap to zero.
        cyc();
        chk_fetch("wrap_a", 1'b1, RST_PC + 32'd4);
        exp_q.push_back(RST_PC + 32'd4);
        cyc();
        chk_fetch("wrap_b", 1'b1, RST_PC + 32'd8);
        pc_control  = 2'd3;
        jump_target = 32'hFFFF_FFFF;
        cyc();
        pc_control = 2'd0;
        chk("wrap_bubble", 32'(valid_d), 32'd0);
        chk_fetch("wrap_top", 1'b1, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        stall = 1'b1;
        cyc();
        chk("empty_stall_valid", 32'(valid_d), 32'd1);
        chk("empty_stall_pc_d", pc_d, 32'hFFFF_FFFC);
        chk_fetch("wrap_zero", 1'b1, 32'h0000_0000);
        exp_q.push_back(32'h0000_0000);
        stall = 1'b0;
        cyc();
        chk("wrap_pc_d", pc_d, 32'h0000_0000);
        chk_fetch("wrap_next", 1'b1, 32'h0000_0004);
        imem_ready = 1'b0;

        repeat (3) cyc();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
